demux_1to2_stream: RTL and testbench

DEMUX_1TO2_STREAM -- requirements
Module: demux_1to2_stream

---
 rtl/demux_1to2_stream_pkg.sv | 22 ++
 rtl/demux_out_slot.sv | 69 ++++++
 rtl/demux_1to2_stream.sv | 66 ++++++
 tb/tb_demux_1to2_stream.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux_1to2_stream_pkg.sv
// Shared mux/demux definitions: default widths, port-select encoding and the
// output slot state type used by the 1:2 stream demultiplexer.
package demux_1to2_stream_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 16;

    // Same polarity as the 2:1 mux a/b select.
    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // A slot can take a word if it is empty, or full and draining this cycle.
    function automatic logic slot_can_load(input slot_state_e state, input logic ready);
        return (state == SLOT_EMPTY) || ((state == SLOT_FULL) && ready);
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output slot with data register and completed-transfer counter.
module demux_out_slot
    import demux_1to2_stream_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             can_load_o
);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             drain_s;

    // Next-state, data and counter logic; a load in the drain cycle refills without a bubble.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        drain_s = (state_q == SLOT_FULL) && ready_i;

        case (state_q)
            SLOT_EMPTY: begin
                if (load_i) state_d = SLOT_FULL;
                else        state_d = SLOT_EMPTY;
            end
            SLOT_FULL: begin
                if (load_i)       state_d = SLOT_FULL;
                else if (drain_s) state_d = SLOT_EMPTY;
                else              state_d = SLOT_FULL;
            end
            default: state_d = SLOT_EMPTY;
        endcase

        if (load_i) data_d = load_data_i;
        else        data_d = data_q;

        if (drain_s) count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        else         count_d = count_q;
    end

    // Slot state, data and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= {WIDTH{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign valid_o    = (state_q == SLOT_FULL);
    assign data_o     = data_q;
    assign count_o    = count_q;
    assign can_load_o = slot_can_load(state_q, ready_i);

endmodule

// File: rtl/demux_1to2_stream.sv
// 1:2 valid/ready stream demultiplexer: steers each accepted word into the
// output slot of port A or port B according to in_sel.
module demux_1to2_stream
    import demux_1to2_stream_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    logic a_can_load_s;
    logic b_can_load_s;
    logic accept_s;
    logic load_a_s;
    logic load_b_s;

    // Only the selected slot gates acceptance, so a stalled port never blocks the other.
    always_comb begin
        in_ready = 1'b0;
        if (rst)                  in_ready = 1'b0;
        else if (in_sel == SEL_A) in_ready = a_can_load_s;
        else                      in_ready = b_can_load_s;
        accept_s = in_valid && in_ready;
        load_a_s = accept_s && (in_sel == SEL_A);
        load_b_s = accept_s && (in_sel == SEL_B);
    end

    demux_out_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_a (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load_a_s),
        .load_data_i (in_data),
        .ready_i     (a_ready),
        .valid_o     (a_valid),
        .data_o      (a_data),
        .count_o     (a_count),
        .can_load_o  (a_can_load_s)
    );

    demux_out_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_b (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load_b_s),
        .load_data_i (in_data),
        .ready_i     (b_ready),
        .valid_o     (b_valid),
        .data_o      (b_data),
        .count_o     (b_count),
        .can_load_o  (b_can_load_s)
    );

endmodule

// File: tb/tb_demux_1to2_stream.sv
// Self-checking bench for demux_1to2_stream: directed table, hand sequences and
// randomized traffic against a queue-based reference model.
module tb_demux_1to2_stream;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a_data;
    logic        a_valid;
    logic        a_ready;
    logic [7:0]  b_data;
    logic        b_valid;
    logic        b_ready;
    logic [15:0] a_count;
    logic [15:0] b_count;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: per-port queue of words waiting on the port, plus counts.
    logic [7:0]  mq_a[$];
    logic [7:0]  mq_b[$];
    logic [15:0] m_ca;
    logic [15:0] m_cb;
    logic        last_acc;

    demux_1to2_stream dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sel;
        logic [7:0] d;
        logic       v;
        logic       ar;
        logic       br;
        logic       e_rdy;
        logic       e_av;
        logic [7:0] e_ad;
        logic       e_bv;
        logic [7:0] e_bd;
        logic [15:0] e_ac;
        logic [15:0] e_bc;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq_a.delete();
        mq_b.delete();
        m_ca = 16'd0;
        m_cb = 16'd0;
    endtask

    // One clock cycle: drive, check all outputs against the model, advance the model.
    task automatic step(input logic sel, input logic [7:0] d, input logic v,
                        input logic ar, input logic br);
        logic exp_rdy;
        in_sel = sel; in_data = d; in_valid = v; a_ready = ar; b_ready = br;
        #1;
        exp_rdy = sel ? ((mq_a.size() == 0) || ar) : ((mq_b.size() == 0) || br);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        chk("a_valid", {31'd0, a_valid}, {31'd0, mq_a.size() != 0});
        chk("b_valid", {31'd0, b_valid}, {31'd0, mq_b.size() != 0});
        if (mq_a.size() != 0) chk("a_data", {24'd0, a_data}, {24'd0, mq_a[0]});
        if (mq_b.size() != 0) chk("b_data", {24'd0, b_data}, {24'd0, mq_b[0]});
        chk("a_count", {16'd0, a_count}, {16'd0, m_ca});
        chk("b_count", {16'd0, b_count}, {16'd0, m_cb});
        @(posedge clk);
        if (mq_a.size() != 0 && ar) begin void'(mq_a.pop_front()); m_ca = m_ca + 16'd1; end
        if (mq_b.size() != 0 && br) begin void'(mq_b.pop_front()); m_cb = m_cb + 16'd1; end
        last_acc = v && exp_rdy;
        if (last_acc) begin
            if (sel) mq_a.push_back(d);
            else     mq_b.push_back(d);
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_sel = 1'b0; in_data = 8'h00; a_ready = 1'b0; b_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int w;
        int start_sum;
        tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'd0, 16'd0};
        tbl[1] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 8'h00, 16'd0, 16'd0};
        tbl[2] = '{1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'd1, 16'd0};
        tbl[3] = '{1'b0, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h11, 16'd1, 16'd0};
        tbl[4] = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h11, 16'd1, 16'd0};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 8'h11, 16'd1, 16'd0};
        tbl[6] = '{1'b0, 8'h22, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 1'b1, 8'h11, 16'd1, 16'd0};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h22, 16'd2, 16'd1};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'd2, 16'd2};

        rst = 1'b1;
        in_valid = 1'b1; in_sel = 1'b1; in_data = 8'hFF; a_ready = 1'b1; b_ready = 1'b1;
        #3;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_a_valid", {31'd0, a_valid}, 32'd0);
        chk("rst_b_valid", {31'd0, b_valid}, 32'd0);
        chk("rst_a_data", {24'd0, a_data}, 32'd0);
        chk("rst_b_data", {24'd0, b_data}, 32'd0);
        chk("rst_a_count", {16'd0, a_count}, 32'd0);
        chk("rst_b_count", {16'd0, b_count}, 32'd0);
        do_reset();

        // Directed table: single transfer, stall on B with bypass to A, dual drain.
        for (int i = 0; i < 9; i++) begin
            in_sel = tbl[i].sel; in_data = tbl[i].d; in_valid = tbl[i].v;
            a_ready = tbl[i].ar; b_ready = tbl[i].br;
            #1;
            chk($sformatf("tbl%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].e_rdy});
            chk($sformatf("tbl%0d_a_valid", i), {31'd0, a_valid}, {31'd0, tbl[i].e_av});
            chk($sformatf("tbl%0d_b_valid", i), {31'd0, b_valid}, {31'd0, tbl[i].e_bv});
            if (tbl[i].e_av) chk($sformatf("tbl%0d_a_data", i), {24'd0, a_data}, {24'd0, tbl[i].e_ad});
            if (tbl[i].e_bv) chk($sformatf("tbl%0d_b_data", i), {24'd0, b_data}, {24'd0, tbl[i].e_bd});
            chk($sformatf("tbl%0d_a_count", i), {16'd0, a_count}, {16'd0, tbl[i].e_ac});
            chk($sformatf("tbl%0d_b_count", i), {16'd0, b_count}, {16'd0, tbl[i].e_bc});
            @(posedge clk);
            #1;
        end

        // Back-to-back stream of 1..10 into port A.
        do_reset();
        for (int k = 1; k <= 10; k++) step(1'b1, k[7:0], 1'b1, 1'b1, 1'($urandom_range(0, 1)));
        step(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("stream_a_count", {16'd0, a_count}, 32'd10);

        // Alternating select, 20 words, random sink readiness.
        start_sum = int'(m_ca) + int'(m_cb);
        w = 0;
        for (int c = 0; c < 400 && w < 20; c++) begin
            step(w[0], 8'($urandom_range(0, 255)), 1'b1,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (last_acc) w++;
        end
        chk("alt_words_sent", w, 32'd20);
        for (int c = 0; c < 4; c++) step(1'($urandom_range(0, 1)), 8'h00, 1'b0, 1'b1, 1'b1);
        chk("alt_count_sum", int'(a_count) + int'(b_count), start_sum + 20);

        // Fully random traffic.
        for (int c = 0; c < 300; c++)
            step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));

        // Asynchronous reset between edges with both slots full.
        step(1'b1, 8'hC3, 1'b1, 1'b1, 1'b1);
        step(1'b0, 8'h3C, 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_a_valid", {31'd0, a_valid}, 32'd1);
        chk("pre_rst_b_valid", {31'd0, b_valid}, 32'd1);
        in_valid = 1'b1; in_sel = 1'b1; a_ready = 1'b1; b_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_a_valid", {31'd0, a_valid}, 32'd0);
        chk("arst_b_valid", {31'd0, b_valid}, 32'd0);
        chk("arst_a_count", {16'd0, a_count}, 32'd0);
        chk("arst_b_count", {16'd0, b_count}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 60; c++)
            step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Counter wrap on port A after 65535 transfers.
        do_reset();
        in_sel = 1'b1; in_valid = 1'b1; a_ready = 1'b1; b_ready = 1'b0;
        for (int i = 0; i < 65535; i++) begin
            in_data = 8'(i);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("wrap_pre_a_count", {16'd0, a_count}, 32'h0000FFFF);
        chk("wrap_pre_a_valid", {31'd0, a_valid}, 32'd0);
        m_ca = 16'hFFFF;
        step(1'b1, 8'h5A, 1'b1, 1'b1, 1'b0);
        step(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("wrap_a_count", {16'd0, a_count}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
